// File: rtl/axis_lut_remapper_if.sv
// AXI4-Stream bundle used on both sides of the LUT remapper.
// Master drives payload and valid, slave drives ready.
interface axis_lut_remapper_if #(
  parameter int DW = 8,
  parameter int KW = 1
);
  logic [DW-1:0] tdata;
  logic [KW-1:0] tkeep;
  logic          tvalid;
  logic          tready;
  logic          tlast;
  logic          tuser;

  modport master (
    output tdata,
    output tkeep,
    output tvalid,
    output tlast,
    output tuser,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    input  tuser,
    output tready
  );
endinterface

// File: rtl/axis_lut_remapper.sv
// Ping-pong LUT pixel remapper with lane packer for the
// histogram-equalizer video path.
module axis_lut_remapper #(
  parameter int DATA_IN_WIDTH  = 14,
  parameter int DATA_OUT_WIDTH = 8,
  parameter int PACK           = 4
) (
  input  logic                      axis_aclk,
  input  logic                      axis_areset,
  axis_lut_remapper_if.slave        s_axis,
  axis_lut_remapper_if.master       m_axis,
  input  logic                      lut_we,
  input  logic [DATA_IN_WIDTH-1:0]  lut_addr,
  input  logic [DATA_OUT_WIDTH-1:0] lut_din,
  input  logic                      lut_swap_req,
  output logic                      lut_swap_done,
  output logic                      lut_bank_active,
  input  logic                      bypass,
  output logic                      err_sof_misalign,
  input  logic                      err_clear
);

  localparam int AW = DATA_IN_WIDTH;
  localparam int DW = DATA_OUT_WIDTH;
  localparam int OW = PACK * DW;
  localparam int LW = (PACK > 1) ? $clog2(PACK) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(PACK - 1);

  logic [DW-1:0] lut_mem [2**(AW+1)];

  logic adv;
  logic acc;
  logic sof_acc;
  logic swap_now;
  logic bank_sel;
  logic byp_now;
  logic pk_fire;
  logic close;

  logic bank_q;
  logic pend_q;
  logic done_q;
  logic byp_q;
  logic err_q;
  logic err_d;

  logic          s1_vld_q;
  logic          s1_last_q;
  logic          s1_user_q;
  logic          s1_byp_q;
  logic [DW-1:0] s1_bd_q;
  logic [DW-1:0] s1_rd_q;

  logic          s2_vld_q;
  logic          s2_last_q;
  logic          s2_user_q;
  logic [DW-1:0] s2_pix_q;

  logic [LW-1:0]   lane_q;
  logic [LW-1:0]   lane_d;
  logic [OW-1:0]   pk_data_q;
  logic [OW-1:0]   pk_data_d;
  logic [PACK-1:0] pk_keep_q;
  logic [PACK-1:0] pk_keep_d;
  logic            pk_user_q;
  logic            pk_user_d;

  logic [OW-1:0]   fill_data;
  logic [PACK-1:0] fill_keep;
  logic            fill_user;

  logic [OW-1:0]   m_data_q;
  logic [OW-1:0]   m_data_d;
  logic [PACK-1:0] m_keep_q;
  logic [PACK-1:0] m_keep_d;
  logic            m_vld_q;
  logic            m_vld_d;
  logic            m_last_q;
  logic            m_last_d;
  logic            m_user_q;
  logic            m_user_d;

  // Whole pipeline moves as one; only a held output beat stalls it.
  assign adv      = !m_vld_q | m_axis.tready;
  assign s_axis.tready = adv & !axis_areset;
  assign acc      = s_axis.tvalid & s_axis.tready;
  assign sof_acc  = acc & s_axis.tuser;
  assign swap_now = sof_acc & pend_q;
  // The SOF pixel that triggers a swap already reads the new bank.
  assign bank_sel = bank_q ^ swap_now;
  assign byp_now  = sof_acc ? bypass : byp_q;
  assign pk_fire  = adv & s2_vld_q;
  assign close    = (lane_q == LAST_LANE) | s2_last_q;

  assign m_axis.tdata  = m_data_q;
  assign m_axis.tkeep  = m_keep_q;
  assign m_axis.tvalid = m_vld_q;
  assign m_axis.tlast  = m_last_q;
  assign m_axis.tuser  = m_user_q;

  assign lut_swap_done    = done_q;
  assign lut_bank_active  = bank_q;
  assign err_sof_misalign = err_q;

  // LUT write port, always into the bank not being read.
  always_ff @(posedge axis_aclk) begin
    if (lut_we) begin
      lut_mem[{~bank_q, lut_addr}] <= lut_din;
    end
  end

  // LUT read port, enabled by pipeline advance (contents never reset).
  always_ff @(posedge axis_aclk) begin
    if (adv) begin
      s1_rd_q <= lut_mem[{bank_sel, s_axis.tdata}];
    end
  end

  // Sticky misalignment flag; clear wins over a same-cycle set.
  always_comb begin
    err_d = err_q;
    if (pk_fire && s2_user_q && (lane_q != '0)) begin
      err_d = 1'b1;
    end
    if (err_clear) begin
      err_d = 1'b0;
    end
  end

  // Bank swap, frame bypass latch and status registers.
  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      bank_q <= 1'b0;
      pend_q <= 1'b0;
      done_q <= 1'b0;
      byp_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= swap_now;
      err_q  <= err_d;
      if (swap_now) begin
        bank_q <= ~bank_q;
      end
      if (swap_now) begin
        pend_q <= 1'b0;
      end else if (lut_swap_req) begin
        pend_q <= 1'b1;
      end
      if (sof_acc) begin
        byp_q <= bypass;
      end
    end
  end

  // S1/S2 qualifiers and the RAM output register with bypass mux.
  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      s1_user_q <= 1'b0;
      s1_byp_q  <= 1'b0;
      s1_bd_q   <= '0;
      s2_vld_q  <= 1'b0;
      s2_last_q <= 1'b0;
      s2_user_q <= 1'b0;
      s2_pix_q  <= '0;
    end else if (adv) begin
      s1_vld_q  <= acc;
      s1_last_q <= s_axis.tlast;
      s1_user_q <= s_axis.tuser;
      s1_byp_q  <= byp_now;
      s1_bd_q   <= s_axis.tdata[AW-1 -: DW];
      s2_vld_q  <= s1_vld_q;
      s2_last_q <= s1_last_q;
      s2_user_q <= s1_user_q;
      s2_pix_q  <= s1_byp_q ? s1_bd_q : s1_rd_q;
    end
  end

  // Packer: drop the pixel into its lane, close on last lane or tlast.
  always_comb begin
    fill_data = pk_data_q;
    fill_data[lane_q*DW +: DW] = s2_pix_q;
    fill_keep = pk_keep_q | (PACK'(1) << lane_q);
    fill_user = pk_user_q | s2_user_q;

    lane_d    = lane_q;
    pk_data_d = pk_data_q;
    pk_keep_d = pk_keep_q;
    pk_user_d = pk_user_q;
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    m_vld_d   = m_vld_q;
    m_last_d  = m_last_q;
    m_user_d  = m_user_q;

    if (pk_fire) begin
      if (close) begin
        m_data_d  = fill_data;
        m_keep_d  = fill_keep;
        m_last_d  = s2_last_q;
        m_user_d  = fill_user;
        m_vld_d   = 1'b1;
        pk_data_d = '0;
        pk_keep_d = '0;
        pk_user_d = 1'b0;
        lane_d    = '0;
      end else begin
        pk_data_d = fill_data;
        pk_keep_d = fill_keep;
        pk_user_d = fill_user;
        lane_d    = lane_q + 1'b1;
        m_vld_d   = 1'b0;
      end
    end else if (adv) begin
      m_vld_d = 1'b0;
    end
  end

  // Packer partial beat and S3 output register.
  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      lane_q    <= '0;
      pk_data_q <= '0;
      pk_keep_q <= '0;
      pk_user_q <= 1'b0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_vld_q   <= 1'b0;
      m_last_q  <= 1'b0;
      m_user_q  <= 1'b0;
    end else begin
      lane_q    <= lane_d;
      pk_data_q <= pk_data_d;
      pk_keep_q <= pk_keep_d;
      pk_user_q <= pk_user_d;
      m_data_q  <= m_data_d;
      m_keep_q  <= m_keep_d;
      m_vld_q   <= m_vld_d;
      m_last_q  <= m_last_d;
      m_user_q  <= m_user_d;
    end
  end

endmodule

// File: tb/tb_axis_lut_remapper.sv
// Bench for axis_lut_remapper: pixel-level model and scoreboard
// plus directed frames with literal expectations.
module tb_axis_lut_remapper;

  localparam int PK = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        lut_we;
  logic [13:0] lut_addr;
  logic [7:0]  lut_din;
  logic        swap_req;
  logic        done;
  logic        bank;
  logic        bypass;
  logic        err;
  logic        err_clear;

  axis_lut_remapper_if #(.DW(14), .KW(1)) s_if ();
  axis_lut_remapper_if #(.DW(32), .KW(4)) m_if ();

  axis_lut_remapper #(
    .DATA_IN_WIDTH(14),
    .DATA_OUT_WIDTH(8),
    .PACK(PK)
  ) dut (
    .axis_aclk(clk),
    .axis_areset(rst),
    .s_axis(s_if),
    .m_axis(m_if),
    .lut_we(lut_we),
    .lut_addr(lut_addr),
    .lut_din(lut_din),
    .lut_swap_req(swap_req),
    .lut_swap_done(done),
    .lut_bank_active(bank),
    .bypass(bypass),
    .err_sof_misalign(err),
    .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  bit chk_en = 0;
  bit rnd_rdy = 0;

  logic [7:0]  lutm [2][16384];
  bit          m_bank, m_pend, m_byp, m_err, m_done;
  int          m_lane;
  logic [31:0] p_data;
  logic [3:0]  p_keep;
  bit          p_user;
  logic [37:0] exp_q[$];
  logic [37:0] got_q[$];
  bit          stall_prev;
  logic [37:0] stall_beat;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    m_if.tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Compare DUT against the model, then step the model by this cycle's inputs.
  always @(negedge clk) begin
    logic [37:0] beat;
    logic [7:0]  v;
    bit          swapped;
    if (chk_en) begin
      chk("swap_done", done, m_done);
      chk("bank_active", bank, m_bank);
      if (done) done_cnt++;
      beat = {m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser};
      if (stall_prev) begin
        chk("hold_valid", m_if.tvalid, 1);
        if (m_if.tvalid) chk("hold_beat", beat, stall_beat);
      end
      if (m_if.tvalid && m_if.tready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL beat: got %0h, none expected", beat);
        end else begin
          chk("beat", beat, exp_q.pop_front());
        end
        got_q.push_back(beat);
      end
      stall_prev = m_if.tvalid && !m_if.tready;
      stall_beat = beat;
    end
    if (rst) begin
      m_bank = 0; m_pend = 0; m_byp = 0; m_err = 0; m_done = 0;
      m_lane = 0; p_data = 0; p_keep = 0; p_user = 0;
      exp_q.delete();
      stall_prev = 0;
    end else begin
      swapped = 0;
      m_done = 0;
      if (lut_we) lutm[!m_bank][lut_addr] = lut_din;
      if (s_if.tvalid && s_if.tready) begin
        if (s_if.tuser) begin
          if (m_pend) begin
            m_bank = !m_bank; m_pend = 0; m_done = 1; swapped = 1;
          end
          m_byp = bypass;
          if (m_lane != 0) m_err = 1;
        end
        v = m_byp ? s_if.tdata[13:6] : lutm[m_bank][s_if.tdata];
        p_data[m_lane*8 +: 8] = v;
        p_keep[m_lane] = 1'b1;
        p_user = p_user | s_if.tuser;
        if (m_lane == PK-1 || s_if.tlast) begin
          exp_q.push_back({p_data, p_keep, s_if.tlast, p_user});
          p_data = 0; p_keep = 0; p_user = 0; m_lane = 0;
        end else begin
          m_lane++;
        end
      end
      if (swap_req && !m_pend && !swapped) m_pend = 1;
      if (err_clear) m_err = 0;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [13:0] d, input bit sof, input bit last);
    int n = 0;
    bit r;
    s_if.tdata = d;
    s_if.tuser = sof;
    s_if.tlast = last;
    s_if.tvalid = 1'b1;
    while (1) begin
      @(negedge clk);
      r = s_if.tready;
      @(posedge clk);
      #1;
      if (r) break;
      n++;
      if (n > 200) begin
        total++;
        bad++;
        $display("FAIL send_timeout: pixel %0h not accepted", d);
        break;
      end
    end
    s_if.tvalid = 1'b0;
  endtask

  task automatic pulse_swap();
    swap_req = 1'b1;
    idle(1);
    swap_req = 1'b0;
  endtask

  task automatic drain();
    rnd_rdy = 0;
    idle(30);
  endtask

  initial begin
    logic [13:0] a;
    int dc, t0, sent, lines, len;
    rst = 1; lut_we = 0; lut_addr = 0; lut_din = 0; swap_req = 0;
    bypass = 0; err_clear = 0;
    s_if.tdata = 0; s_if.tkeep = 1'b1; s_if.tvalid = 0;
    s_if.tlast = 0; s_if.tuser = 0;
    m_if.tready = 1;
    @(posedge clk);
    #1;
    chk_en = 1;
    idle(1);
    chk("rst_tvalid", m_if.tvalid, 0);
    chk("rst_tdata", m_if.tdata, 0);
    chk("rst_tkeep", m_if.tkeep, 0);
    chk("rst_tlast_tuser", {m_if.tlast, m_if.tuser}, 0);
    chk("rst_status", {done, bank, err}, 0);
    chk("rst_tready", s_if.tready, 0);
    rst = 0;
    idle(2);

    // Bank 1 = i[13:6], swap, one 8-pixel frame.
    for (int i = 0; i < 16384; i++) begin
      a = 14'(i);
      lut_we = 1; lut_addr = a; lut_din = a[13:6];
      idle(1);
    end
    lut_we = 0;
    pulse_swap();
    got_q.delete();
    for (int k = 0; k < 8; k++) send(14'(k*64), k == 0, k == 7);
    drain();
    chk("f1_beats", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("f1_beat0", got_q[0], {32'h03020100, 4'hF, 1'b0, 1'b1});
      chk("f1_beat1", got_q[1], {32'h07060504, 4'hF, 1'b1, 1'b0});
    end
    chk("f1_bank", bank, 1);
    chk("f1_done_cnt", done_cnt, 1);

    // Six-pixel line gives a partial beat, next line restarts at lane 0.
    got_q.delete();
    for (int k = 0; k < 6; k++) send(14'(k*64), k == 0, k == 5);
    for (int k = 0; k < 4; k++) send(14'((8+k)*64), 0, k == 3);
    drain();
    chk("l6_beats", got_q.size(), 3);
    if (got_q.size() == 3) begin
      chk("l6_beat1", got_q[1], {32'h00000504, 4'h3, 1'b1, 1'b0});
      chk("l6_beat2", got_q[2], {32'h0B0A0908, 4'hF, 1'b1, 1'b0});
    end

    // SOF on lane 2.
    got_q.delete();
    for (int k = 0; k < 4; k++) send(14'(k*64), k == 2, k == 3);
    drain();
    chk("mis_beat", got_q.size() > 0 ? got_q[0] : 38'h0,
        {32'h03020100, 4'hF, 1'b1, 1'b1});
    chk("mis_err", err, 1);
    chk("mis_err_model", err, m_err);
    err_clear = 1;
    idle(1);
    err_clear = 0;
    chk("err_cleared", err, 0);

    // Random contents into bank 0, swap on the burst's SOF.
    for (int i = 0; i < 16384; i++) begin
      lut_we = 1; lut_addr = 14'(i); lut_din = 8'($urandom);
      idle(1);
    end
    lut_we = 0;
    pulse_swap();
    t0 = cyc;
    for (int k = 0; k < 64; k++)
      send(14'($urandom_range(0, 16383)), k == 0, k % 16 == 15);
    chk("throughput_cycles", cyc - t0, 64);
    drain();
    chk("burst_bank", bank, 0);

    // Random backpressure over ~1024 pixels.
    rnd_rdy = 1;
    sent = 0;
    lines = 0;
    while (sent < 1024) begin
      len = $urandom_range(1, 20);
      for (int j = 0; j < len; j++) begin
        send(14'($urandom_range(0, 16383)), j == 0 && lines % 4 == 0,
             j == len - 1);
        if ($urandom_range(0, 7) == 0) idle(1);
      end
      lines++;
      sent += len;
    end
    drain();
    chk("rand_drained", exp_q.size(), 0);

    // Bypass latched at SOF, mid-frame toggle ignored.
    got_q.delete();
    bypass = 1;
    send(14'h3FFF, 1, 0);
    send(14'h1234, 0, 0);
    bypass = 0;
    send(14'h0040, 0, 0);
    send(14'h0080, 0, 1);
    send(14'h3FFF, 1, 1);
    drain();
    chk("byp_beats", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("byp_beat0", got_q[0], {32'h020148FF, 4'hF, 1'b1, 1'b1});
      chk("byp_next_keep", got_q[1][5:0], {4'h1, 1'b1, 1'b1});
    end

    // Reset mid-frame with partial beat and pending swap.
    pulse_swap();
    for (int k = 0; k < 4; k++) send(14'(k), k == 0, k == 3);
    drain();
    chk("pre_rst_bank", bank, 1);
    dc = done_cnt;
    send(14'h0005, 1, 0);
    send(14'h0006, 0, 0);
    pulse_swap();
    rst = 1;
    #1;
    chk("rst_mid_tready", s_if.tready, 0);
    idle(1);
    chk("rst_mid_tvalid", m_if.tvalid, 0);
    chk("rst_mid_tdata", m_if.tdata, 0);
    chk("rst_mid_bank", bank, 0);
    idle(1);
    rst = 0;
    idle(3);
    got_q.delete();
    for (int k = 0; k < 4; k++) send(14'(k*3), k == 0, k == 3);
    drain();
    chk("post_rst_beats", got_q.size(), 1);
    chk("post_rst_lane0", got_q.size() > 0 ? got_q[0][5:0] : 6'h0,
        {4'hF, 1'b1, 1'b1});
    chk("post_rst_no_done", done_cnt, dc);
    chk("post_rst_bank", bank, 0);
    chk("final_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
